// File: rtl/rast_pkg.sv
// +--------------------------------------------------------------------+
// | rast_pkg : shared rasterizer types (coordinate width, walker FSM    |
// |            states, pixel record)                                    |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

package rast_pkg;

    localparam int COORD_W_DFLT = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RUN   = 2'd2
    } state_t;

    typedef struct packed {
        logic signed [COORD_W_DFLT-1:0] x;
        logic signed [COORD_W_DFLT-1:0] y;
        logic                           last;
    } pixel_t;

endpackage

`default_nettype wire

// File: rtl/line_setup.sv
// +--------------------------------------------------------------------+
// | line_setup : combinational Bresenham setup - deltas, steep detect,  |
// |              endpoint ordering, minor step sign and initial error   |
// | Revision   : 1.0                                                    |
// +--------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module line_setup
    import rast_pkg::*;
#(
    parameter int COORD_W = COORD_W_DFLT
) (
    input  logic signed [COORD_W-1:0] x0_i,
    input  logic signed [COORD_W-1:0] y0_i,
    input  logic signed [COORD_W-1:0] x1_i,
    input  logic signed [COORD_W-1:0] y1_i,
    output logic                      steep_o,
    output logic signed [COORD_W-1:0] maj_start_o,
    output logic signed [COORD_W-1:0] min_start_o,
    output logic signed [COORD_W-1:0] maj_end_o,
    output logic        [COORD_W:0]   dmaj_o,
    output logic        [COORD_W:0]   dmin_o,
    output logic                      step_neg_o,
    output logic signed [COORD_W+2:0] err_o
);

    logic signed [COORD_W:0]   dx;
    logic signed [COORD_W:0]   dy;
    logic signed [COORD_W:0]   dminor;
    logic        [COORD_W:0]   adx;
    logic        [COORD_W:0]   ady;
    logic signed [COORD_W-1:0] ma0;
    logic signed [COORD_W-1:0] ma1;
    logic signed [COORD_W-1:0] mi0;
    logic signed [COORD_W-1:0] mi1;
    logic signed [COORD_W-1:0] min_end;
    logic                      swap;

    always_comb begin
        // One extra bit keeps the full endpoint difference exact
        dx      = {x1_i[COORD_W-1], x1_i} - {x0_i[COORD_W-1], x0_i};
        dy      = {y1_i[COORD_W-1], y1_i} - {y0_i[COORD_W-1], y0_i};
        adx     = dx[COORD_W] ? -dx : dx;
        ady     = dy[COORD_W] ? -dy : dy;
        steep_o = (ady > adx);

        ma0 = steep_o ? y0_i : x0_i;
        ma1 = steep_o ? y1_i : x1_i;
        mi0 = steep_o ? x0_i : y0_i;
        mi1 = steep_o ? x1_i : y1_i;

        swap        = (ma1 < ma0);
        maj_start_o = swap ? ma1 : ma0;
        maj_end_o   = swap ? ma0 : ma1;
        min_start_o = swap ? mi1 : mi0;
        min_end     = swap ? mi0 : mi1;

        dmaj_o = steep_o ? ady : adx;
        dmin_o = steep_o ? adx : ady;

        dminor     = {min_end[COORD_W-1], min_end} - {min_start_o[COORD_W-1], min_start_o};
        step_neg_o = dminor[COORD_W];

        err_o = $signed({1'b0, dmin_o, 1'b0}) - $signed({2'b00, dmaj_o});
    end

endmodule

`default_nettype wire

// File: rtl/line_walker.sv
// +--------------------------------------------------------------------+
// | line_walker : sequential Bresenham walker, one segment in, one      |
// |               pixel per cycle out over valid/ready                  |
// | Revision    : 1.0                                                   |
// +--------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module line_walker
    import rast_pkg::*;
#(
    parameter int COORD_W = COORD_W_DFLT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [COORD_W-1:0] x0,
    input  logic signed [COORD_W-1:0] y0,
    input  logic signed [COORD_W-1:0] x1,
    input  logic signed [COORD_W-1:0] y1,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [COORD_W-1:0] out_x,
    output logic signed [COORD_W-1:0] out_y,
    output logic                      out_last,
    output logic                      busy
);

    localparam logic signed [COORD_W-1:0] c_one = 1;

    state_t                    state_q, state_d;
    logic signed [COORD_W-1:0] ex0_q, ex0_d, ey0_q, ey0_d, ex1_q, ex1_d, ey1_q, ey1_d;
    logic                      steep_q, steep_d;
    logic signed [COORD_W-1:0] maj_q, maj_d, min_q, min_d, maj_end_q, maj_end_d;
    logic        [COORD_W:0]   dmaj_q, dmaj_d, dmin_q, dmin_d;
    logic                      step_neg_q, step_neg_d;
    logic signed [COORD_W+2:0] err_q, err_d;

    logic                      s_steep;
    logic signed [COORD_W-1:0] s_maj_start, s_min_start, s_maj_end;
    logic        [COORD_W:0]   s_dmaj, s_dmin;
    logic                      s_step_neg;
    logic signed [COORD_W+2:0] s_err;
    logic signed [COORD_W+2:0] err_inc, err_dec;

    line_setup #(
        .COORD_W (COORD_W)
    ) u_setup (
        .x0_i        (ex0_q),
        .y0_i        (ey0_q),
        .x1_i        (ex1_q),
        .y1_i        (ey1_q),
        .steep_o     (s_steep),
        .maj_start_o (s_maj_start),
        .min_start_o (s_min_start),
        .maj_end_o   (s_maj_end),
        .dmaj_o      (s_dmaj),
        .dmin_o      (s_dmin),
        .step_neg_o  (s_step_neg),
        .err_o       (s_err)
    );

    assign err_inc = $signed({1'b0, dmin_q, 1'b0});
    assign err_dec = $signed({1'b0, dmin_q, 1'b0}) - $signed({1'b0, dmaj_q, 1'b0});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ex0_q      <= '0;
            ey0_q      <= '0;
            ex1_q      <= '0;
            ey1_q      <= '0;
            steep_q    <= 1'b0;
            maj_q      <= '0;
            min_q      <= '0;
            maj_end_q  <= '0;
            dmaj_q     <= '0;
            dmin_q     <= '0;
            step_neg_q <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            ex0_q      <= ex0_d;
            ey0_q      <= ey0_d;
            ex1_q      <= ex1_d;
            ey1_q      <= ey1_d;
            steep_q    <= steep_d;
            maj_q      <= maj_d;
            min_q      <= min_d;
            maj_end_q  <= maj_end_d;
            dmaj_q     <= dmaj_d;
            dmin_q     <= dmin_d;
            step_neg_q <= step_neg_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ex0_d      = ex0_q;
        ey0_d      = ey0_q;
        ex1_d      = ex1_q;
        ey1_d      = ey1_q;
        steep_d    = steep_q;
        maj_d      = maj_q;
        min_d      = min_q;
        maj_end_d  = maj_end_q;
        dmaj_d     = dmaj_q;
        dmin_d     = dmin_q;
        step_neg_d = step_neg_q;
        err_d      = err_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        busy       = (state_q != IDLE);
        out_x      = steep_q ? min_q : maj_q;
        out_y      = steep_q ? maj_q : min_q;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ex0_d   = x0;
                    ey0_d   = y0;
                    ex1_d   = x1;
                    ey1_d   = y1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                steep_d    = s_steep;
                maj_d      = s_maj_start;
                min_d      = s_min_start;
                maj_end_d  = s_maj_end;
                dmaj_d     = s_dmaj;
                dmin_d     = s_dmin;
                step_neg_d = s_step_neg;
                err_d      = s_err;
                state_d    = RUN;
            end
            RUN: begin
                out_valid = 1'b1;
                out_last  = (maj_q == maj_end_q);
                if (out_ready) begin
                    if (out_last) begin
                        state_d = IDLE;
                    end else begin
                        maj_d = maj_q + c_one;
                        // Minor axis advances only on a strictly positive error
                        if (!err_q[COORD_W+2] && (err_q != '0)) begin
                            min_d = step_neg_q ? (min_q - c_one) : (min_q + c_one);
                            err_d = err_q + err_dec;
                        end else begin
                            err_d = err_q + err_inc;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

`default_nettype wire
